// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the PC, issues one request at a time to instruction
// memory, and hands each returned word with its PC to decode over valid/ready.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_instr_pc;

  logic        w_req_fire;
  logic        w_redirect;
  logic        w_capture;
  logic [31:0] w_redirect_pc;

  assign w_req_fire    = (r_state == S_REQ) && imem_req_ready;
  // A redirect before the first request is ignored so the reset PC is always fetched first.
  assign w_redirect    = redirect_valid && (r_state != S_IDLE);
  assign w_capture     = (r_state == S_WAIT) && imem_rsp_valid && !redirect_valid;
  assign w_redirect_pc = redirect_pc & ~32'h3;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: w_state_next = S_REQ;
      S_REQ: begin
        if (w_req_fire) begin
          w_state_next = redirect_valid ? S_DRAIN : S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          w_state_next = redirect_valid ? S_REQ : S_HOLD;
        end else if (redirect_valid) begin
          w_state_next = S_DRAIN;
        end
      end
      S_HOLD: begin
        if (redirect_valid || instr_ready) begin
          w_state_next = S_REQ;
        end
      end
      S_DRAIN: begin
        // The stale response is gone once it arrives; waiting further would never end.
        if (imem_rsp_valid) begin
          w_state_next = S_REQ;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req_valid = (r_state == S_REQ);
    instr_valid    = (r_state == S_HOLD);
    imem_req_addr  = r_pc;
    instr          = r_instr;
    instr_pc       = r_instr_pc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_instr    <= 32'h0;
      r_instr_pc <= 32'h0;
    end else begin
      if (w_redirect) begin
        r_pc <= w_redirect_pc;
      end else if (w_capture) begin
        r_pc <= r_pc + 32'd4;
      end
      if (w_capture) begin
        r_instr    <= imem_rsp_data;
        r_instr_pc <= r_pc;
      end
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: a per-cycle vector table of inputs and expected
// outputs, followed by hand-written mid-operation reset and backpressure sequences.
module tb_ifu_fetch;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  ifu_fetch #(.RESET_PC(32'h8000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic        rspv;
    logic [31:0] rspd;
    logic        irdy;
    logic        redv;
    logic [31:0] redpc;
    logic        e_rv;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_instr;
    logic [31:0] e_ipc;
  } vec_t;

  vec_t vq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  localparam logic [31:0] A0 = 32'h0000_0013, A1 = 32'h0010_0093, A2 = 32'h0020_0113;
  localparam logic [31:0] B0 = 32'h0030_0193, C0 = 32'h0040_0213, D0 = 32'h0050_0293;
  localparam logic [31:0] F0 = 32'h0060_0313;
  localparam logic [31:0] STALE = 32'hDEAD_BEEF;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  // Inputs are applied during the cycle whose state the expected outputs describe.
  task automatic add(input logic rdy, input logic rspv, input logic [31:0] rspd,
                     input logic irdy, input logic redv, input logic [31:0] redpc,
                     input logic e_rv, input logic [31:0] e_addr, input logic e_iv,
                     input logic [31:0] e_instr, input logic [31:0] e_ipc);
    vec_t v;
    v.rdy = rdy; v.rspv = rspv; v.rspd = rspd; v.irdy = irdy; v.redv = redv;
    v.redpc = redpc; v.e_rv = e_rv; v.e_addr = e_addr; v.e_iv = e_iv;
    v.e_instr = e_instr; v.e_ipc = e_ipc;
    vq.push_back(v);
  endtask

  task automatic drive(input logic rdy, input logic rspv, input logic [31:0] rspd,
                       input logic irdy, input logic redv, input logic [31:0] redpc);
    imem_req_ready = rdy;
    imem_rsp_valid = rspv;
    imem_rsp_data  = rspd;
    instr_ready    = irdy;
    redirect_valid = redv;
    redirect_pc    = redpc;
  endtask

  initial begin
    int cyc;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);

    // rdy rspv rspd irdy redv redpc | req_valid addr instr_valid instr instr_pc
    add(1,0,0,    0,0,0,            1,32'h8000_0000,0,32'h0,32'h0);         // REQ
    add(0,1,A0,   0,0,0,            0,32'h8000_0000,0,32'h0,32'h0);         // WAIT
    add(0,0,0,    1,0,0,            0,32'h8000_0004,1,A0,32'h8000_0000);    // HOLD
    add(1,0,0,    0,0,0,            1,32'h8000_0004,0,A0,32'h8000_0000);
    add(0,1,A1,   0,0,0,            0,32'h8000_0004,0,A0,32'h8000_0000);
    add(0,0,0,    1,0,0,            0,32'h8000_0008,1,A1,32'h8000_0004);
    add(1,0,0,    0,0,0,            1,32'h8000_0008,0,A1,32'h8000_0004);
    add(0,1,A2,   0,0,0,            0,32'h8000_0008,0,A1,32'h8000_0004);
    for (int k = 0; k < 5; k++)                                              // decode backpressure
      add(0,0,0,  0,0,0,            0,32'h8000_000C,1,A2,32'h8000_0008);
    add(0,0,0,    1,0,0,            0,32'h8000_000C,1,A2,32'h8000_0008);
    for (int k = 0; k < 4; k++)                                              // memory not ready
      add(0,0,0,  0,0,0,            1,32'h8000_000C,0,A2,32'h8000_0008);
    add(1,0,0,    0,0,0,            1,32'h8000_000C,0,A2,32'h8000_0008);
    add(0,0,0,    0,1,32'h8000_1002,0,32'h8000_000C,0,A2,32'h8000_0008);    // redirect in WAIT
    add(0,1,STALE,0,0,0,            0,32'h8000_1000,0,A2,32'h8000_0008);    // DRAIN drops rsp
    add(1,0,0,    0,0,0,            1,32'h8000_1000,0,A2,32'h8000_0008);
    add(0,1,B0,   0,0,0,            0,32'h8000_1000,0,A2,32'h8000_0008);
    add(0,0,0,    1,1,32'hFFFF_FFFC,0,32'h8000_1004,1,B0,32'h8000_1000);    // redirect in HOLD
    add(1,0,0,    0,0,0,            1,32'hFFFF_FFFC,0,B0,32'h8000_1000);
    add(0,1,C0,   0,0,0,            0,32'hFFFF_FFFC,0,B0,32'h8000_1000);
    add(0,0,0,    1,0,0,            0,32'h0000_0000,1,C0,32'hFFFF_FFFC);    // PC wraps
    add(0,0,0,    0,1,32'h8000_2000,1,32'h0000_0000,0,C0,32'hFFFF_FFFC);    // redirect, no handshake
    add(1,0,0,    0,1,32'h8000_3000,1,32'h8000_2000,0,C0,32'hFFFF_FFFC);    // redirect with handshake
    add(0,0,0,    0,0,0,            0,32'h8000_3000,0,C0,32'hFFFF_FFFC);    // DRAIN waits
    add(0,1,STALE,0,0,0,            0,32'h8000_3000,0,C0,32'hFFFF_FFFC);
    add(1,1,STALE,0,0,0,            1,32'h8000_3000,0,C0,32'hFFFF_FFFC);    // rsp in REQ ignored
    add(0,1,STALE,0,1,32'h8000_4000,0,32'h8000_3000,0,C0,32'hFFFF_FFFC);    // rsp+redirect in WAIT
    add(1,0,0,    0,0,0,            1,32'h8000_4000,0,C0,32'hFFFF_FFFC);
    add(0,1,D0,   0,0,0,            0,32'h8000_4000,0,C0,32'hFFFF_FFFC);
    add(0,1,STALE,0,0,0,            0,32'h8000_4004,1,D0,32'h8000_4000);    // rsp in HOLD ignored
    add(0,0,0,    1,0,0,            0,32'h8000_4004,1,D0,32'h8000_4000);
    add(1,0,0,    0,0,0,            1,32'h8000_4004,0,D0,32'h8000_4000);

    repeat (2) @(negedge clk);
    chk("reset req_valid",   {31'h0, imem_req_valid}, 32'h0);
    chk("reset instr_valid", {31'h0, instr_valid},    32'h0);
    chk("reset addr",        imem_req_addr,           32'h8000_0000);
    chk("reset instr",       instr,                   32'h0);
    chk("reset instr_pc",    instr_pc,                32'h0);
    rst = 1'b0;
    @(negedge clk);  // IDLE cycle

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      chk($sformatf("v%0d req_valid", i),   {31'h0, imem_req_valid}, {31'h0, vq[i].e_rv});
      chk($sformatf("v%0d addr", i),        imem_req_addr,           vq[i].e_addr);
      chk($sformatf("v%0d instr_valid", i), {31'h0, instr_valid},    {31'h0, vq[i].e_iv});
      chk($sformatf("v%0d instr", i),       instr,                   vq[i].e_instr);
      chk($sformatf("v%0d instr_pc", i),    instr_pc,                vq[i].e_ipc);
      $display("[TB] vec %0d: req_valid=%0b addr=%08h instr_valid=%0b instr=%08h instr_pc=%08h",
               i, imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc);
      drive(vq[i].rdy, vq[i].rspv, vq[i].rspd, vq[i].irdy, vq[i].redv, vq[i].redpc);
    end

    // Reset while a request is outstanding; the late response and an IDLE redirect are ignored.
    @(negedge clk);
    chk("pre-reset WAIT req_valid", {31'h0, imem_req_valid}, 32'h0);
    chk("pre-reset WAIT addr",      imem_req_addr,           32'h8000_4004);
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("midrst req_valid",   {31'h0, imem_req_valid}, 32'h0);
    chk("midrst instr_valid", {31'h0, instr_valid},    32'h0);
    chk("midrst addr",        imem_req_addr,           32'h8000_0000);
    chk("midrst instr",       instr,                   32'h0);
    chk("midrst instr_pc",    instr_pc,                32'h0);
    $display("[TB] mid-op reset: addr=%08h instr=%08h", imem_req_addr, instr);
    rst = 1'b0;
    drive(0, 1, STALE, 0, 1, 32'h1234_5678);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      chk($sformatf("stall%0d req_valid", k), {31'h0, imem_req_valid}, 32'h1);
      chk($sformatf("stall%0d addr", k),      imem_req_addr,           32'h8000_0000);
      chk($sformatf("stall%0d instr", k),     instr,                   32'h0);
      $display("[TB] stall %0d: req_valid=%0b addr=%08h", k, imem_req_valid, imem_req_addr);
    end
    imem_req_ready = 1'b1;
    @(negedge clk);
    drive(0, 1, F0, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    cyc = 0;
    while (!instr_valid && cyc < 8) begin
      @(negedge clk);
      cyc++;
    end
    chk("post-reset instr_valid", {31'h0, instr_valid}, 32'h1);
    chk("post-reset instr",       instr,                F0);
    chk("post-reset instr_pc",    instr_pc,             32'h8000_0000);
    $display("[TB] post-reset fetch: instr=%08h instr_pc=%08h", instr, instr_pc);
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    chk("post-reset next req_valid", {31'h0, imem_req_valid}, 32'h1);
    chk("post-reset next addr",      imem_req_addr,           32'h8000_0004);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
